// File: rtl/pipelined_alu_stream_if.sv
// Handshake bundle for pipelined_alu_stream: operand request channel in,
// result/flag channel out, plus the completed-op counter.
interface pipelined_alu_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [3:0]       op_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
  logic             zero_out;
  logic             neg_out;
  logic             ovf_out;
  logic             err_out;
  logic [CNT_W-1:0] op_count;

  // ALU side
  modport slave (
    input  in_valid, a_in, b_in, op_in, out_ready,
    output in_ready, out_valid, alu_out, carry_out, zero_out, neg_out,
           ovf_out, err_out, op_count
  );

  // producer/consumer side
  modport master (
    output in_valid, a_in, b_in, op_in, out_ready,
    input  in_ready, out_valid, alu_out, carry_out, zero_out, neg_out,
           ovf_out, err_out, op_count
  );
endinterface

// File: rtl/pipelined_alu_stream.sv
// 2-stage valid/ready ALU: S1 holds the operand request, S2 holds the
// registered result and flags. Full throughput with backpressure.
// Optional feature: define PALU_SAT_EN to enable opcodes A/B (signed
// saturating add/sub); without it they behave as reserved opcodes.
module pipelined_alu_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_alu_stream_if.slave bus
);
  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SLL = 4'h6, OP_SRL = 4'h7,
    OP_SRA = 4'h8, OP_SLT = 4'h9, OP_ADDS = 4'hA, OP_SUBS = 4'hB
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
    logic             e;
  } rsp_t;

  req_t             s1_q;
  logic             s1_valid;
  rsp_t             s2_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic s2_load, accept, xfer, in_ready_w;

  assign xfer       = out_valid_q && bus.out_ready;
  assign s2_load    = s1_valid && (!out_valid_q || bus.out_ready);
  // Gated by rst_n so the producer sees "not ready" throughout reset.
  assign in_ready_w = rst_n && (!s1_valid || s2_load);
  assign accept     = bus.in_valid && in_ready_w;

  // Execute datapath (between S1 and S2)
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   sum, diff, sll_w, srl_w, sra_w;
  logic             add_ovf, sub_ovf, big, slt;
  rsp_t             exe;

  assign a       = s1_q.a;
  assign b       = s1_q.b;
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign add_ovf = (a[M] == b[M]) && (sum[M] != a[M]);
  assign sub_ovf = (a[M] != b[M]) && (diff[M] != a[M]);
  assign big     = (b >= WIDTH'(WIDTH));
  assign slt     = $signed(a) < $signed(b);
  // One extra bit on the exit side of each shift catches the last bit
  // shifted out; with b=0 that bit is the padding zero, so carry is 0.
  assign sll_w   = {1'b0, a} << b;
  assign srl_w   = {a, 1'b0} >> b;
  assign sra_w   = $signed({a, 1'b0}) >>> b;

  // Opcode decode; zero/neg are derived from the final result here so they
  // register alongside it and read 0 out of reset.
  always_comb begin
    exe = '0;
    case (s1_q.op)
      OP_ADD:  begin exe.r = sum[M:0];  exe.c = sum[WIDTH];  exe.v = add_ovf; end
      OP_SUB:  begin exe.r = diff[M:0]; exe.c = diff[WIDTH]; exe.v = sub_ovf; end
      OP_AND:  exe.r = a & b;
      OP_OR:   exe.r = a | b;
      OP_XOR:  exe.r = a ^ b;
      OP_NOT:  exe.r = ~a;
      OP_SLL:  if (!big) begin exe.r = sll_w[M:0]; exe.c = sll_w[WIDTH]; end
      OP_SRL:  if (!big) begin exe.r = srl_w[WIDTH:1]; exe.c = srl_w[0]; end
      OP_SRA:  begin
        if (big) exe.r = {WIDTH{a[M]}};
        else begin exe.r = sra_w[WIDTH:1]; exe.c = sra_w[0]; end
      end
      OP_SLT:  exe.r = {{(WIDTH-1){1'b0}}, slt};
`ifdef PALU_SAT_EN
      OP_ADDS: begin
        exe.r = add_ovf ? (a[M] ? SMIN : SMAX) : sum[M:0];
        exe.v = add_ovf;
      end
      OP_SUBS: begin
        exe.r = sub_ovf ? (a[M] ? SMIN : SMAX) : diff[M:0];
        exe.v = sub_ovf;
      end
`endif
      default: exe.e = 1'b1;
    endcase
    exe.z = (exe.r == '0);
    exe.n = exe.r[M];
  end

  // S1: capture a request on accept, empty when it moves to S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_q     <= '{a: bus.a_in, b: bus.b_in, op: bus.op_in};
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: load a new result (may replace one leaving this edge), else drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q        <= '0;
      out_valid_q <= 1'b0;
    end else if (s2_load) begin
      s2_q        <= exe;
      out_valid_q <= 1'b1;
    end else if (xfer) begin
      out_valid_q <= 1'b0;
    end
  end

  // Completed-op counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = s2_q.r;
  assign bus.carry_out = s2_q.c;
  assign bus.zero_out  = s2_q.z;
  assign bus.neg_out   = s2_q.n;
  assign bus.ovf_out   = s2_q.v;
  assign bus.err_out   = s2_q.e;
  assign bus.op_count  = cnt_q;
endmodule
